// File: rtl/pipe_control.sv
// pipe_control: SimpleRISC 5-stage control unit. Decodes the ID instruction,
// carries control down ID/EX, EX/MA and MA/RW, and raises stall/flush for fetch.
// Ports: clk, rst_n (async active-low); id_inst/id_valid (ID stage);
// ex_branch_taken, mem_busy (pipeline status); stall, flush (to fetch);
// ex_*/ma_*/rw_* control for the EX, MA and RW datapaths.
module pipe_control #(
    parameter int INST_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_W  = 4,
    parameter int RA_IDX = 15,
    parameter int FWD    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_valid,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              stall,
    output logic              flush,
    output logic              ex_valid,
    output logic              ex_isImmediate,
    output logic              ex_isLd,
    output logic              ex_isSt,
    output logic              ex_isWb,
    output logic              ex_isBeq,
    output logic              ex_isBgt,
    output logic              ex_isUBranch,
    output logic              ex_isCall,
    output logic              ex_isRet,
    output logic [OPC_W-1:0]  ex_aluSignals,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ma_valid,
    output logic              ma_isLd,
    output logic              ma_isSt,
    output logic              ma_isWb,
    output logic [REG_W-1:0]  ma_rd,
    output logic              rw_valid,
    output logic              rw_isWb,
    output logic [REG_W-1:0]  rw_rd
);

    typedef struct packed {
        logic             valid;
        logic             imm;
        logic             ld;
        logic             st;
        logic             wb;
        logic             beq;
        logic             bgt;
        logic             ubr;
        logic             call;
        logic             ret;
        logic [OPC_W-1:0] alu;
        logic [REG_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic             valid;
        logic             ld;
        logic             st;
        logic             wb;
        logic [REG_W-1:0] rd;
    } ma_ctrl_t;

    typedef struct packed {
        logic             valid;
        logic             wb;
        logic [REG_W-1:0] rd;
    } rw_ctrl_t;

    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_MOD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_ASR  = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(17);
    localparam logic [OPC_W-1:0] OP_B    = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(19);
    localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(20);
    localparam logic [REG_W-1:0] RA      = REG_W'(RA_IDX);

    localparam int I_POS   = INST_W - OPC_W - 1;
    localparam int RD_TOP  = I_POS - 1;
    localparam int RS1_TOP = RD_TOP - REG_W;
    localparam int RS2_TOP = RS1_TOP - REG_W;

    ex_ctrl_t ex_ctrl_q, ex_ctrl_d;
    ma_ctrl_t ma_ctrl_q, ma_ctrl_d;
    rw_ctrl_t rw_ctrl_q, rw_ctrl_d;
    ex_ctrl_t dec;

    logic [OPC_W-1:0] opc;
    logic             imm_bit;
    logic [REG_W-1:0] f_rd;
    logic [REG_W-1:0] f_rs1;
    logic [REG_W-1:0] f_rs2;
    logic             known;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_rd;
    logic             use_ra;
    logic             hz_ex;
    logic             hz_ma;
    logic             hz_rw;
    logic             hazard;
    logic             take_br;

    assign opc     = id_inst[INST_W-1 -: OPC_W];
    assign imm_bit = id_inst[I_POS];
    assign f_rd    = id_inst[RD_TOP -: REG_W];
    assign f_rs1   = id_inst[RS1_TOP -: REG_W];
    assign f_rs2   = id_inst[RS2_TOP -: REG_W];

    // Opcodes above ret are undefined and travel as bubbles.
    assign known = id_valid && (opc <= OP_RET);

    always_comb begin
        dec       = '0;
        dec.valid = known;
        dec.imm   = known && imm_bit;
        dec.ld    = known && (opc == OP_LD);
        dec.st    = known && (opc == OP_ST);
        dec.beq   = known && (opc == OP_BEQ);
        dec.bgt   = known && (opc == OP_BGT);
        dec.ubr   = known && (opc == OP_B);
        dec.call  = known && (opc == OP_CALL);
        dec.ret   = known && (opc == OP_RET);
        dec.wb    = known && ((opc <= OP_MOD)
                    || (opc >= OP_AND && opc <= OP_ASR)
                    || (opc == OP_LD) || (opc == OP_CALL));
        dec.alu   = known ? opc : '0;
        if (known)
            dec.rd = (opc == OP_CALL) ? RA : f_rd;
    end

    always_comb begin
        use_rs1 = (opc <= OP_OR)
                || (opc >= OP_LSL && opc <= OP_ASR)
                || (opc == OP_LD) || (opc == OP_ST);
        use_rs2 = !imm_bit && (opc <= OP_ASR);
        use_rd  = (opc == OP_ST);
        use_ra  = (opc == OP_RET);
    end

    function automatic logic src_hit(input logic [REG_W-1:0] r);
        return (use_rs1 && f_rs1 == r) || (use_rs2 && f_rs2 == r)
            || (use_rd && f_rd == r) || (use_ra && r == RA);
    endfunction

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hz_ex = ex_ctrl_q.valid && ex_ctrl_q.wb
                && src_hit(ex_ctrl_q.rd)
                && ((FWD != 0) ? ex_ctrl_q.ld : 1'b1);
    assign hz_ma = (FWD == 0) && ma_ctrl_q.valid && ma_ctrl_q.wb
                && src_hit(ma_ctrl_q.rd);
    assign hz_rw = (FWD == 0) && rw_ctrl_q.valid && rw_ctrl_q.wb
                && src_hit(rw_ctrl_q.rd);

    assign hazard  = id_valid && (hz_ex || hz_ma || hz_rw);
    assign take_br = ex_ctrl_q.valid && ex_branch_taken;

    always_comb begin
        stall     = 1'b0;
        flush     = 1'b0;
        ex_ctrl_d = ex_ctrl_q;
        ma_ctrl_d = ma_ctrl_q;
        rw_ctrl_d = rw_ctrl_q;
        if (mem_busy) begin
            stall = 1'b1;
        end else begin
            ma_ctrl_d = '{valid: ex_ctrl_q.valid, ld: ex_ctrl_q.ld,
                          st: ex_ctrl_q.st, wb: ex_ctrl_q.wb,
                          rd: ex_ctrl_q.rd};
            rw_ctrl_d = '{valid: ma_ctrl_q.valid, wb: ma_ctrl_q.wb,
                          rd: ma_ctrl_q.rd};
            if (take_br) begin
                flush     = 1'b1;
                ex_ctrl_d = '0;
            end else if (hazard) begin
                stall     = 1'b1;
                ex_ctrl_d = '0;
            end else begin
                ex_ctrl_d = dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q <= '0;
            ma_ctrl_q <= '0;
            rw_ctrl_q <= '0;
        end else begin
            ex_ctrl_q <= ex_ctrl_d;
            ma_ctrl_q <= ma_ctrl_d;
            rw_ctrl_q <= rw_ctrl_d;
        end
    end

    assign ex_valid       = ex_ctrl_q.valid;
    assign ex_isImmediate = ex_ctrl_q.imm;
    assign ex_isLd        = ex_ctrl_q.ld;
    assign ex_isSt        = ex_ctrl_q.st;
    assign ex_isWb        = ex_ctrl_q.wb;
    assign ex_isBeq       = ex_ctrl_q.beq;
    assign ex_isBgt       = ex_ctrl_q.bgt;
    assign ex_isUBranch   = ex_ctrl_q.ubr;
    assign ex_isCall      = ex_ctrl_q.call;
    assign ex_isRet       = ex_ctrl_q.ret;
    assign ex_aluSignals  = ex_ctrl_q.alu;
    assign ex_rd          = ex_ctrl_q.rd;
    assign ma_valid       = ma_ctrl_q.valid;
    assign ma_isLd        = ma_ctrl_q.ld;
    assign ma_isSt        = ma_ctrl_q.st;
    assign ma_isWb        = ma_ctrl_q.wb;
    assign ma_rd          = ma_ctrl_q.rd;
    assign rw_valid       = rw_ctrl_q.valid;
    assign rw_isWb        = rw_ctrl_q.wb;
    assign rw_rd          = rw_ctrl_q.rd;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: drives a forwarding and a non-forwarding pipe_control
// with the same stimulus and checks both against a stage-list model.
module tb_pipe_control;

    localparam logic [31:0] ADD1  = 32'h0048C000;
    localparam logic [31:0] ADD31 = 32'h00C48000;
    localparam logic [31:0] LD1   = 32'h74480004;
    localparam logic [31:0] BEQ   = 32'h80000000;
    localparam logic [31:0] CALL  = 32'h98000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_branch_taken;
    logic        mem_busy;

    // Index 1: FWD=1 instance, index 0: FWD=0 instance.
    logic [1:0][18:0] o_ex;
    logic [1:0][7:0]  o_ma;
    logic [1:0][5:0]  o_rw;
    logic [1:0]       o_stall;
    logic [1:0]       o_flush;

    int errors = 0;
    int checks = 0;

    // Model: per instance, records for EX, MA, RW as
    // {v,imm,ld,st,wb,beq,bgt,b,call,ret,alu[4:0],rd[3:0]}.
    logic [18:0] m [2][3];
    logic [1:0]  seen_stall;
    logic [1:0]  seen_flush;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_control #(.FWD(g)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .id_inst(id_inst),
            .id_valid(id_valid),
            .ex_branch_taken(ex_branch_taken),
            .mem_busy(mem_busy),
            .stall(o_stall[g]),
            .flush(o_flush[g]),
            .ex_valid(o_ex[g][18]),
            .ex_isImmediate(o_ex[g][17]),
            .ex_isLd(o_ex[g][16]),
            .ex_isSt(o_ex[g][15]),
            .ex_isWb(o_ex[g][14]),
            .ex_isBeq(o_ex[g][13]),
            .ex_isBgt(o_ex[g][12]),
            .ex_isUBranch(o_ex[g][11]),
            .ex_isCall(o_ex[g][10]),
            .ex_isRet(o_ex[g][9]),
            .ex_aluSignals(o_ex[g][8:4]),
            .ex_rd(o_ex[g][3:0]),
            .ma_valid(o_ma[g][7]),
            .ma_isLd(o_ma[g][6]),
            .ma_isSt(o_ma[g][5]),
            .ma_isWb(o_ma[g][4]),
            .ma_rd(o_ma[g][3:0]),
            .rw_valid(o_rw[g][5]),
            .rw_isWb(o_rw[g][4]),
            .rw_rd(o_rw[g][3:0])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] mdec(input logic [31:0] inst,
                                         input logic iv);
        int op;
        logic wb;
        logic [3:0] rd;
        op = int'(inst[31:27]);
        if (!iv || op > 20) return '0;
        wb = (op <= 4) || (op >= 6 && op <= 12) || op == 14 || op == 19;
        rd = (op == 19) ? 4'd15 : inst[25:22];
        return {1'b1, inst[26], op == 14, op == 15, wb, op == 16,
                op == 17, op == 18, op == 19, op == 20, inst[31:27], rd};
    endfunction

    function automatic logic uses(input logic [31:0] inst,
                                  input logic [3:0] r);
        int op;
        logic u;
        op = int'(inst[31:27]);
        u = 1'b0;
        if (op <= 7 || (op >= 10 && op <= 12) || op == 14 || op == 15)
            u = u | (inst[21:18] == r);
        if (!inst[26] && op <= 12) u = u | (inst[17:14] == r);
        if (op == 15) u = u | (inst[25:22] == r);
        if (op == 20) u = u | (r == 4'd15);
        return u;
    endfunction

    function automatic logic mhz(input int d);
        logic [18:0] rec;
        if (!id_valid) return 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (d == 1 && s > 0) break;
            rec = m[d][s];
            if (rec[18] && rec[14] && uses(id_inst, rec[3:0])
                && (d == 0 || rec[16]))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] pma(input logic [18:0] r);
        return {r[18], r[16], r[15], r[14], r[3:0]};
    endfunction

    function automatic logic [5:0] prw(input logic [18:0] r);
        return {r[18], r[14], r[3:0]};
    endfunction

    task automatic mclear();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 3; s++) m[d][s] = '0;
    endtask

    // One clock: settle, compare against model, clock, advance model.
    task automatic step();
        logic [1:0] bub;
        logic br;
        logic stl;
        #1;
        for (int d = 0; d < 2; d++) begin
            br  = m[d][0][18] && ex_branch_taken && !mem_busy;
            stl = mem_busy || (!br && mhz(d));
            bub[d] = br || stl;
            seen_stall[d] = o_stall[d];
            seen_flush[d] = o_flush[d];
            chk($sformatf("stall%0d", d), 32'(o_stall[d]), 32'(stl));
            chk($sformatf("flush%0d", d), 32'(o_flush[d]), 32'(br));
            chk($sformatf("ex%0d", d), 32'(o_ex[d]), 32'(m[d][0]));
            chk($sformatf("ma%0d", d), 32'(o_ma[d]), 32'(pma(m[d][1])));
            chk($sformatf("rw%0d", d), 32'(o_rw[d]), 32'(prw(m[d][2])));
        end
        @(posedge clk);
        if (!mem_busy) begin
            for (int d = 0; d < 2; d++) begin
                m[d][2] = m[d][1];
                m[d][1] = m[d][0];
                m[d][0] = bub[d] ? 19'd0 : mdec(id_inst, id_valid);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ex"}, 32'(o_ex[d]), 32'd0);
            chk({tag, "_ma"}, 32'(o_ma[d]), 32'd0);
            chk({tag, "_rw"}, 32'(o_rw[d]), 32'd0);
            chk({tag, "_sf"}, 32'({o_stall[d], o_flush[d]}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int n;
        logic [18:0] snap_ex;
        logic [7:0]  snap_ma;
        logic [5:0]  snap_rw;
        logic [3:0]  rr [4];

        rr[0] = 4'd0; rr[1] = 4'd1; rr[2] = 4'd2; rr[3] = 4'd15;
        rst_n = 1'b0;
        id_inst = '0;
        id_valid = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        mclear();
        #3;
        chk_zero("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight-line add r1,r2,r3.
        id_inst = ADD1; id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        chk("sl_ex", 32'(o_ex[1]), 32'h44001);
        step();
        step();
        chk("sl_rw", 32'(o_rw[1]), 32'h31);

        // Load-use with forwarding: one bubble.
        idle(3);
        id_inst = LD1; id_valid = 1'b1;
        step();
        id_inst = ADD31;
        s = 0; n = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            s += int'(seen_stall[1]);
            n++;
            if (o_ex[1][18] && o_ex[1][3:0] == 4'd3) break;
        end
        id_valid = 1'b0;
        chk("lu_stalls", 32'(s), 32'd1);
        chk("lu_lat", 32'(n), 32'd2);

        // RAW without forwarding: three bubbles.
        idle(3);
        id_inst = ADD1; id_valid = 1'b1;
        step();
        id_inst = ADD31;
        s = 0; n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            s += int'(seen_stall[0]);
            n++;
            if (o_ex[0][18] && o_ex[0][3:0] == 4'd3) break;
        end
        id_valid = 1'b0;
        chk("raw_stalls", 32'(s), 32'd3);
        chk("raw_lat", 32'(n), 32'd4);

        // Taken branch beats a pending hazard.
        idle(3);
        id_inst = ADD1; id_valid = 1'b1;
        step();
        id_inst = BEQ;
        step();
        id_inst = ADD31; ex_branch_taken = 1'b1;
        step();
        chk("br_flush", 32'(seen_flush[0]), 32'd1);
        chk("br_stall", 32'(seen_stall[0]), 32'd0);
        chk("br_bubble", 32'(o_ex[0][18]), 32'd0);
        ex_branch_taken = 1'b0; id_valid = 1'b0;

        // Call destination, then freeze with a taken branch in EX.
        idle(3);
        id_inst = CALL; id_valid = 1'b1;
        step();
        chk("call_rd", 32'(o_ex[1][3:0]), 32'd15);
        chk("call_wb", 32'(o_ex[1][14]), 32'd1);
        id_inst = BEQ;
        step();
        id_valid = 1'b0;
        snap_ex = o_ex[1]; snap_ma = o_ma[1]; snap_rw = o_rw[1];
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        repeat (3) begin
            step();
            chk("mb_stall", 32'(seen_stall[1]), 32'd1);
            chk("mb_flush", 32'(seen_flush[1]), 32'd0);
            chk("mb_hold", 32'({o_ex[1], o_ma[1], o_rw[1]}),
                32'({snap_ex, snap_ma, snap_rw}));
        end
        mem_busy = 1'b0;
        step();
        chk("mb_release_flush", 32'(seen_flush[1]), 32'd1);
        ex_branch_taken = 1'b0;

        // Asynchronous reset in the middle of traffic.
        idle(2);
        id_inst = ADD1; id_valid = 1'b1;
        step();
        chk("pre_rst_valid", 32'(o_ex[1][18]), 32'd1);
        id_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        mclear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with registers drawn from a small pool.
        for (int c = 0; c < 1500; c++) begin
            id_inst = {5'($urandom_range(0, 23)), 1'($urandom_range(0, 1)),
                       rr[$urandom_range(0, 3)], rr[$urandom_range(0, 3)],
                       rr[$urandom_range(0, 3)], 14'($urandom)};
            id_valid = ($urandom_range(0, 7) != 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_busy = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
